// File: rtl/ux607_regbus_pkg.sv
// -----------------------------------------------------------------------------
// ux607_regbus_pkg
// Shared types and defaults for the register-bus target.
//   DEF_*     : default parameter values used by the target and its interface
//   rsp_t     : one response FIFO entry (read, err, data, extra)
//   req_t     : request fields as presented by the upstream request queue
//   rdata_sel : stage-B data select (array data only for in-range reads)
// -----------------------------------------------------------------------------
package ux607_regbus_pkg;

  localparam int DEF_IDX_W     = 10;
  localparam int DEF_EXTRA_W   = 10;
  localparam int DEF_IDX_LIMIT = 1024;
  localparam int DEF_RSP_DEPTH = 2;

  typedef struct packed {
    logic                   read;
    logic                   err;
    logic [31:0]            data;
    logic [DEF_EXTRA_W-1:0] extra;
  } rsp_t;

  typedef struct packed {
    logic                   read;
    logic [DEF_IDX_W-1:0]   index;
    logic [31:0]            data;
    logic [3:0]             mask;
    logic [DEF_EXTRA_W-1:0] extra;
  } req_t;

  // Writes and out-of-range reads return zero data.
  function automatic logic [31:0] rdata_sel(input logic        read,
                                            input logic        err,
                                            input logic [31:0] rdata);
    return (read && !err) ? rdata : 32'h0;
  endfunction

endpackage

// File: rtl/ux607_regbus_if.sv
// -----------------------------------------------------------------------------
// ux607_regbus_if
// Request and response channels of the register-bus target.
//   req_* : valid/ready request channel (read, index, data, mask, extra)
//   rsp_* : valid/ready response channel (read, data, err, extra)
// Modports: slave (the target), master (request source / response sink).
// -----------------------------------------------------------------------------
interface ux607_regbus_if #(
  parameter int IDX_W   = ux607_regbus_pkg::DEF_IDX_W,
  parameter int EXTRA_W = ux607_regbus_pkg::DEF_EXTRA_W
);

  logic               req_valid;
  logic               req_ready;
  logic               req_read;
  logic [IDX_W-1:0]   req_index;
  logic [31:0]        req_data;
  logic [3:0]         req_mask;
  logic [EXTRA_W-1:0] req_extra;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_read;
  logic [31:0]        rsp_data;
  logic               rsp_err;
  logic [EXTRA_W-1:0] rsp_extra;

  modport slave (
    input  req_valid, req_read, req_index, req_data, req_mask, req_extra,
    output req_ready,
    output rsp_valid, rsp_read, rsp_data, rsp_err, rsp_extra,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_read, req_index, req_data, req_mask, req_extra,
    input  req_ready,
    input  rsp_valid, rsp_read, rsp_data, rsp_err, rsp_extra,
    output rsp_ready
  );

endinterface

// File: rtl/ux607_rsp_fifo.sv
// -----------------------------------------------------------------------------
// ux607_rsp_fifo
// Small synchronous FIFO holding responses until the downstream accepts them.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push_i      : write push_data_i (ignored when full and not popping)
//   pop_i       : consume the head entry (ignored when empty)
//   head_o      : head entry, valid while valid_o is high
//   valid_o     : FIFO not empty
//   count_o     : number of stored entries
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
module ux607_rsp_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign pop_en  = pop_i && (count_q != '0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign push_en = push_i && ((count_q != DEPTH_C) || pop_en);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking <= so all flops update from
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy is defined solely by the
  // pointers and count, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/ux607_regbus_target.sv
// -----------------------------------------------------------------------------
// ux607_regbus_target
// Turns queued register requests into single-cycle accesses on a synchronous
// register array (1-cycle read latency) and returns one response per request,
// in acceptance order, through a small response FIFO.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus (slave)    : req_* request channel in, rsp_* response channel out
//   mem_en/mem_wen/mem_addr/mem_wdata/mem_wmask : array access port (out)
//   mem_rdata      : array read data, valid the cycle after a read strobe
// Pipeline: stage A issues the access in the accept cycle; stage B (next
// cycle) combines the in-flight register with mem_rdata and pushes the FIFO.
// EXTRA_W must match the package default because rsp_t is shared.
// -----------------------------------------------------------------------------
module ux607_regbus_target
  import ux607_regbus_pkg::*;
#(
  parameter int IDX_W     = DEF_IDX_W,
  parameter int EXTRA_W   = DEF_EXTRA_W,
  parameter int IDX_LIMIT = DEF_IDX_LIMIT,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  ux607_regbus_if.slave    bus,
  output logic             mem_en,
  output logic             mem_wen,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic [31:0]      mem_rdata
);

  localparam int               CNT_W   = $clog2(RSP_DEPTH + 1);
  localparam logic [IDX_W:0]   LIMIT_C = (IDX_W + 1)'(IDX_LIMIT);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);

  // Stage-B in-flight register.
  logic               infl_valid_q, infl_valid_d;
  logic               infl_read_q,  infl_read_d;
  logic               infl_err_q,   infl_err_d;
  logic [EXTRA_W-1:0] infl_extra_q, infl_extra_d;

  // Held low during reset and for the edge that releases it, so no request is
  // taken while state is still settling.
  logic ready_en_q;

  logic             req_ready;
  logic             accept;
  logic             in_range;
  logic             pop;
  logic [CNT_W:0]   occupancy;
  logic             fifo_valid;
  logic [CNT_W-1:0] fifo_count;
  rsp_t             push_rsp;
  rsp_t             head_rsp;

  // ---------------------------------------------------------------------------
  // Stage A: range check and array access in the accept cycle
  // ---------------------------------------------------------------------------
  assign in_range  = ({1'b0, bus.req_index} < LIMIT_C);
  assign accept    = bus.req_valid && req_ready;

  assign mem_en    = accept && in_range;
  assign mem_wen   = !bus.req_read;
  assign mem_addr  = bus.req_index;
  assign mem_wdata = bus.req_data;
  assign mem_wmask = bus.req_read ? 4'h0 : bus.req_mask;

  // Slots are counted against responses already queued plus the one in flight;
  // a pop this cycle frees a slot. Only registered state and rsp_ready feed
  // this, so there is no path from req_valid to req_ready.
  assign pop       = fifo_valid && bus.rsp_ready;
  assign occupancy = {1'b0, fifo_count}
                   + (CNT_W + 1)'(infl_valid_q)
                   - (CNT_W + 1)'(pop);
  assign req_ready = ready_en_q && (occupancy < DEPTH_C);
  assign bus.req_ready = req_ready;

  always_comb begin
    infl_valid_d = accept;
    infl_read_d  = infl_read_q;
    infl_err_d   = infl_err_q;
    infl_extra_d = infl_extra_q;
    if (accept) begin
      infl_read_d  = bus.req_read;
      infl_err_d   = !in_range;
      infl_extra_d = bus.req_extra;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q   <= 1'b0;
      infl_valid_q <= 1'b0;
      infl_read_q  <= 1'b0;
      infl_err_q   <= 1'b0;
      infl_extra_q <= '0;
    end else begin
      ready_en_q   <= 1'b1;
      infl_valid_q <= infl_valid_d;
      infl_read_q  <= infl_read_d;
      infl_err_q   <= infl_err_d;
      infl_extra_q <= infl_extra_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: build the response while mem_rdata is valid and queue it
  // ---------------------------------------------------------------------------
  always_comb begin
    push_rsp       = '0;
    push_rsp.read  = infl_read_q;
    push_rsp.err   = infl_err_q;
    push_rsp.data  = rdata_sel(infl_read_q, infl_err_q, mem_rdata);
    push_rsp.extra = infl_extra_q;
  end

  ux607_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_rsp_fifo (
    .clk         (clock),
    .rst_n       (reset_n),
    .push_i      (infl_valid_q),
    .push_data_i (push_rsp),
    .pop_i       (pop),
    .head_o      (head_rsp),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  // The head entry only changes on a pop, so rsp_* is stable under backpressure.
  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_read  = head_rsp.read;
  assign bus.rsp_err   = head_rsp.err;
  assign bus.rsp_data  = head_rsp.data;
  assign bus.rsp_extra = head_rsp.extra;

endmodule
